// File: rtl/rob_pkg.sv
// Shared reorder-buffer types: entry record, wrap-bit pointer and plain index.
// PREG_W tracks the physical register index width used elsewhere in the core.
package rob_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int PREG_W    = 6;
  localparam int IDX_W     = $clog2(ROB_DEPTH);

  typedef logic [PREG_W-1:0] PREG_T;
  typedef logic [IDX_W:0]    ROB_PTR_T;
  typedef logic [IDX_W-1:0]  ROB_IDX_T;

  typedef struct packed {
    logic  valid;
    logic  complete;
    PREG_T T_new;
    PREG_T T_old;
  } ROB_ENTRY_T;

endpackage

// File: rtl/rob_cdb_cam.sv
// Compares every CDB broadcast against the destination tag of every live ROB entry.
// A set hit bit means that entry completes at the next clock edge.
module rob_cdb_cam
  import rob_pkg::*;
#(
  parameter int CDB_W = 2
) (
  input  logic [ROB_DEPTH-1:0]       entry_valid,
  input  PREG_T [ROB_DEPTH-1:0]      entry_tag,
  input  logic [CDB_W-1:0]           cdb_valid,
  input  logic [CDB_W*PREG_W-1:0]    cdb_tag,
  output logic [ROB_DEPTH-1:0]       hit
);

  always_comb begin
    hit = '0;
    for (int e = 0; e < ROB_DEPTH; e++) begin
      for (int p = 0; p < CDB_W; p++) begin
        if (entry_valid[e] && cdb_valid[p] && (entry_tag[e] == cdb_tag[p*PREG_W +: PREG_W])) begin
          hit[e] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rob_ss.sv
// Superscalar reorder buffer: in-order dispatch and retire around a circular entry table,
// with out-of-order completion from the CDB, partial squash to a branch and full flush.
module rob_ss
  import rob_pkg::*;
#(
  parameter int DISP_W = 2,
  parameter int RET_W  = 2,
  parameter int CDB_W  = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush_all,
  input  logic [DISP_W-1:0]        disp_en,
  input  logic [DISP_W*PREG_W-1:0] disp_T_new,
  input  logic [DISP_W*PREG_W-1:0] disp_T_old,
  output logic                     disp_stall,
  output logic [DISP_W*IDX_W-1:0]  disp_idx,
  input  logic [CDB_W-1:0]         cdb_valid,
  input  logic [CDB_W*PREG_W-1:0]  cdb_tag,
  input  logic                     squash_en,
  input  logic [IDX_W-1:0]         squash_idx,
  output logic [RET_W-1:0]         ret_valid,
  output logic [RET_W*PREG_W-1:0]  ret_T_free,
  output logic [RET_W*PREG_W-1:0]  ret_T_arch,
  output logic [IDX_W:0]           free_entries,
  output logic                     full,
  output logic                     empty
);

  ROB_ENTRY_T [ROB_DEPTH-1:0] entries_q, entries_n;
  ROB_PTR_T                   head_q, head_n, tail_q, tail_n;
  ROB_PTR_T                   occupancy, disp_count, ret_count;
  ROB_IDX_T                   head_idx, tail_idx, squash_off;
  logic [ROB_DEPTH-1:0]       entry_valid, cdb_hit;
  PREG_T [ROB_DEPTH-1:0]      entry_tag;
  logic                       ret_chain;

  assign head_idx     = head_q[IDX_W-1:0];
  assign tail_idx     = tail_q[IDX_W-1:0];
  assign occupancy    = tail_q - head_q;
  assign free_entries = ROB_PTR_T'(ROB_DEPTH) - occupancy;
  assign full         = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign empty        = (head_q == tail_q);
  // Age of the squashing branch relative to the oldest entry.
  assign squash_off   = squash_idx - head_idx;

  always_comb begin
    entry_valid = '0;
    entry_tag   = '0;
    for (int e = 0; e < ROB_DEPTH; e++) begin
      entry_valid[e] = entries_q[e].valid;
      entry_tag[e]   = entries_q[e].T_new;
    end
  end

  rob_cdb_cam #(
    .CDB_W (CDB_W)
  ) u_cam (
    .entry_valid (entry_valid),
    .entry_tag   (entry_tag),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .hit         (cdb_hit)
  );

  // Dispatch is all-or-nothing against the occupancy held before this cycle's retire.
  always_comb begin
    disp_count = '0;
    disp_idx   = '0;
    for (int i = 0; i < DISP_W; i++) begin
      disp_count = disp_count + ROB_PTR_T'(disp_en[i]);
      disp_idx[i*IDX_W +: IDX_W] = tail_idx + ROB_IDX_T'(i);
    end
    disp_stall = flush_all || squash_en || (disp_count > free_entries);
  end

  // Retire lanes stop at the first incomplete entry and never pass a squashing branch.
  always_comb begin
    ret_valid  = '0;
    ret_T_free = '0;
    ret_T_arch = '0;
    ret_count  = '0;
    ret_chain  = 1'b1;
    for (int k = 0; k < RET_W; k++) begin
      ret_chain = ret_chain
                  && entries_q[head_idx + ROB_IDX_T'(k)].valid
                  && entries_q[head_idx + ROB_IDX_T'(k)].complete
                  && (!squash_en || (ROB_IDX_T'(k) <= squash_off));
      if (ret_chain) begin
        ret_valid[k]                  = 1'b1;
        ret_T_free[k*PREG_W +: PREG_W] = entries_q[head_idx + ROB_IDX_T'(k)].T_old;
        ret_T_arch[k*PREG_W +: PREG_W] = entries_q[head_idx + ROB_IDX_T'(k)].T_new;
        ret_count                     = ret_count + ROB_PTR_T'(1);
      end
    end
  end

  always_comb begin
    entries_n = entries_q;
    head_n    = head_q + ret_count;
    tail_n    = tail_q;

    for (int e = 0; e < ROB_DEPTH; e++) begin
      if (cdb_hit[e]) begin
        entries_n[e].complete = 1'b1;
      end
    end

    for (int k = 0; k < RET_W; k++) begin
      if (ret_valid[k]) begin
        entries_n[head_idx + ROB_IDX_T'(k)] = '0;
      end
    end

    if (flush_all) begin
      entries_n = '0;
      head_n    = '0;
      tail_n    = '0;
    end else if (squash_en) begin
      // New tail sits just past the branch; adding from head keeps the wrap bit consistent.
      tail_n = head_q + ROB_PTR_T'(squash_off) + ROB_PTR_T'(1);
      for (int e = 0; e < ROB_DEPTH; e++) begin
        if (ROB_IDX_T'(ROB_IDX_T'(e) - head_idx) > squash_off) begin
          entries_n[e] = '0;
        end
      end
    end else if (!disp_stall) begin
      for (int i = 0; i < DISP_W; i++) begin
        if (disp_en[i]) begin
          entries_n[tail_idx + ROB_IDX_T'(i)].valid    = 1'b1;
          entries_n[tail_idx + ROB_IDX_T'(i)].complete = 1'b0;
          entries_n[tail_idx + ROB_IDX_T'(i)].T_new    = disp_T_new[i*PREG_W +: PREG_W];
          entries_n[tail_idx + ROB_IDX_T'(i)].T_old    = disp_T_old[i*PREG_W +: PREG_W];
        end
      end
      tail_n = tail_q + disp_count;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      entries_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
    end else begin
      entries_q <= entries_n;
      head_q    <= head_n;
      tail_q    <= tail_n;
    end
  end

  squash_target_valid: assert property (
    @(posedge clock) disable iff (reset)
    (squash_en && !flush_all) |-> entries_q[squash_idx].valid
  );

endmodule

// File: tb/tb_rob_ss.sv
// Bench for rob_ss: directed vectors and corner sequences plus a randomized run,
// all checked every cycle against a queue-based model of the in-flight instructions.
module tb_rob_ss;
  import rob_pkg::*;

  localparam int DISP_W = 2;
  localparam int RET_W  = 2;
  localparam int CDB_W  = 2;

  logic                     clock;
  logic                     reset;
  logic                     flush_all;
  logic [DISP_W-1:0]        disp_en;
  logic [DISP_W*PREG_W-1:0] disp_T_new;
  logic [DISP_W*PREG_W-1:0] disp_T_old;
  logic                     disp_stall;
  logic [DISP_W*IDX_W-1:0]  disp_idx;
  logic [CDB_W-1:0]         cdb_valid;
  logic [CDB_W*PREG_W-1:0]  cdb_tag;
  logic                     squash_en;
  logic [IDX_W-1:0]         squash_idx;
  logic [RET_W-1:0]         ret_valid;
  logic [RET_W*PREG_W-1:0]  ret_T_free;
  logic [RET_W*PREG_W-1:0]  ret_T_arch;
  logic [IDX_W:0]           free_entries;
  logic                     full;
  logic                     empty;

  rob_ss #(
    .DISP_W (DISP_W),
    .RET_W  (RET_W),
    .CDB_W  (CDB_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .flush_all    (flush_all),
    .disp_en      (disp_en),
    .disp_T_new   (disp_T_new),
    .disp_T_old   (disp_T_old),
    .disp_stall   (disp_stall),
    .disp_idx     (disp_idx),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .squash_en    (squash_en),
    .squash_idx   (squash_idx),
    .ret_valid    (ret_valid),
    .ret_T_free   (ret_T_free),
    .ret_T_arch   (ret_T_arch),
    .free_entries (free_entries),
    .full         (full),
    .empty        (empty)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic              flush;
    logic [1:0]        den;
    logic [PREG_W-1:0] tn0, to0, tn1, to1;
    logic [1:0]        cv;
    logic [PREG_W-1:0] ct0, ct1;
    logic              sq;
    logic [IDX_W-1:0]  sidx;
  } stim_t;

  typedef struct {
    logic [1:0]        den;
    logic [PREG_W-1:0] tn0, to0, tn1, to1;
    logic              exp_stall;
    logic [7:0]        exp_idx;
    logic [4:0]        exp_free;
    logic              exp_full;
  } vec_t;

  // Model: program-ordered list of in-flight instructions plus the slot of the oldest.
  typedef struct {
    logic [PREG_W-1:0] tn;
    logic [PREG_W-1:0] to;
    bit                done;
  } ment_t;

  ment_t mq[$];
  int    mhead;
  stim_t cur;
  int    tests_run;
  int    tests_failed;
  int    tag_ctr;
  vec_t  fill_tab[10];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.flush = 1'b0; s.den = 2'b00;
    s.tn0 = '0; s.to0 = '0; s.tn1 = '0; s.to1 = '0;
    s.cv = 2'b00; s.ct0 = '0; s.ct1 = '0;
    s.sq = 1'b0; s.sidx = '0;
    return s;
  endfunction

  function automatic stim_t dispPair(input logic [1:0] den, input int tn0, input int to0,
                                     input int tn1, input int to1);
    stim_t s = idle();
    s.den = den;
    s.tn0 = PREG_W'(tn0); s.to0 = PREG_W'(to0);
    s.tn1 = PREG_W'(tn1); s.to1 = PREG_W'(to1);
    return s;
  endfunction

  function automatic stim_t cdbStim(input logic [1:0] cv, input int ct0, input int ct1);
    stim_t s = idle();
    s.cv  = cv;
    s.ct0 = PREG_W'(ct0);
    s.ct1 = PREG_W'(ct1);
    return s;
  endfunction

  function automatic int sqOffset(input stim_t s);
    return ((int'(s.sidx) - mhead) % ROB_DEPTH + ROB_DEPTH) % ROB_DEPTH;
  endfunction

  function automatic int retireCount(input stim_t s);
    int lim = RET_W;
    int n = 0;
    if (s.sq && (sqOffset(s) + 1 < lim)) lim = sqOffset(s) + 1;
    while (n < lim && n < mq.size() && mq[n].done) n++;
    return n;
  endfunction

  function automatic bit modelStall(input stim_t s);
    int lanes = int'(s.den[0]) + int'(s.den[1]);
    return s.sq || s.flush || (lanes > ROB_DEPTH - mq.size());
  endfunction

  function automatic void modelStep(input stim_t s);
    int r = retireCount(s);
    bit st = modelStall(s);
    if (s.flush) begin
      mq.delete();
      mhead = 0;
      return;
    end
    foreach (mq[j]) begin
      if ((s.cv[0] && mq[j].tn == s.ct0) || (s.cv[1] && mq[j].tn == s.ct1)) mq[j].done = 1'b1;
    end
    if (s.sq) begin
      int keep = sqOffset(s) + 1;
      while (mq.size() > keep) void'(mq.pop_back());
    end
    for (int k = 0; k < r; k++) void'(mq.pop_front());
    mhead = (mhead + r) % ROB_DEPTH;
    if (!st) begin
      if (s.den[0]) mq.push_back('{tn: s.tn0, to: s.to0, done: 1'b0});
      if (s.den[1]) mq.push_back('{tn: s.tn1, to: s.to1, done: 1'b0});
    end
  endfunction

  task automatic checkOutput();
    int r = retireCount(cur);
    logic [RET_W-1:0]        ev = '0;
    logic [RET_W*PREG_W-1:0] ef = '0;
    logic [RET_W*PREG_W-1:0] ea = '0;
    logic [DISP_W*IDX_W-1:0] ei = '0;
    for (int k = 0; k < r; k++) begin
      ev[k] = 1'b1;
      ef[k*PREG_W +: PREG_W] = mq[k].to;
      ea[k*PREG_W +: PREG_W] = mq[k].tn;
    end
    for (int i = 0; i < DISP_W; i++) begin
      ei[i*IDX_W +: IDX_W] = IDX_W'((mhead + mq.size() + i) % ROB_DEPTH);
    end
    check("ret_valid",    32'(ret_valid),    32'(ev));
    check("ret_T_free",   32'(ret_T_free),   32'(ef));
    check("ret_T_arch",   32'(ret_T_arch),   32'(ea));
    check("free_entries", 32'(free_entries), 32'(ROB_DEPTH - mq.size()));
    check("full",         32'(full),         32'(mq.size() == ROB_DEPTH));
    check("empty",        32'(empty),        32'(mq.size() == 0));
    check("disp_stall",   32'(disp_stall),   32'(modelStall(cur)));
    check("disp_idx",     32'(disp_idx),     32'(ei));
  endtask

  task automatic driveOnly(input stim_t s);
    cur        = s;
    flush_all  = s.flush;
    disp_en    = s.den;
    disp_T_new = {s.tn1, s.tn0};
    disp_T_old = {s.to1, s.to0};
    cdb_valid  = s.cv;
    cdb_tag    = {s.ct1, s.ct0};
    squash_en  = s.sq;
    squash_idx = s.sidx;
  endtask

  task automatic applyStimulus(input stim_t s);
    driveOnly(s);
    #2;
    checkOutput();
  endtask

  task automatic tick();
    @(posedge clock);
    modelStep(cur);
    #1;
  endtask

  task automatic doReset();
    driveOnly(idle());
    reset = 1'b1;
    mq.delete();
    mhead = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [PREG_W-1:0] pickTag();
    if (mq.size() > 0 && $urandom_range(0, 4) != 0) return mq[$urandom_range(0, mq.size() - 1)].tn;
    return PREG_W'($urandom);
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    tests_run    = 0;
    tests_failed = 0;
    tag_ctr      = 0;
    mhead        = 0;

    for (int j = 0; j < 8; j++) begin
      fill_tab[j].den       = 2'b11;
      fill_tab[j].tn0       = PREG_W'(16 + 2*j);
      fill_tab[j].to0       = PREG_W'(40 + 2*j);
      fill_tab[j].tn1       = PREG_W'(17 + 2*j);
      fill_tab[j].to1       = PREG_W'(41 + 2*j);
      fill_tab[j].exp_stall = 1'b0;
      fill_tab[j].exp_idx   = {4'(2*j + 1), 4'(2*j)};
      fill_tab[j].exp_free  = 5'(16 - 2*j);
      fill_tab[j].exp_full  = 1'b0;
    end
    fill_tab[8] = '{den: 2'b11, tn0: 6'd60, to0: 6'd61, tn1: 6'd62, to1: 6'd63,
                    exp_stall: 1'b1, exp_idx: 8'h10, exp_free: 5'd0, exp_full: 1'b1};
    fill_tab[9] = '{den: 2'b00, tn0: 6'd0, to0: 6'd0, tn1: 6'd0, to1: 6'd0,
                    exp_stall: 1'b0, exp_idx: 8'h10, exp_free: 5'd0, exp_full: 1'b1};

    // Reset values, then an asynchronous reset with five entries in flight.
    doReset();
    applyStimulus(idle());
    check("rst_empty",     32'(empty),        32'd1);
    check("rst_free",      32'(free_entries), 32'd16);
    check("rst_ret_valid", 32'(ret_valid),    32'd0);
    check("rst_disp_idx",  32'(disp_idx),     32'h10);
    tick();
    applyStimulus(dispPair(2'b11, 1, 21, 2, 22)); tick();
    applyStimulus(dispPair(2'b11, 3, 23, 4, 24)); tick();
    applyStimulus(dispPair(2'b01, 5, 25, 0, 0));  tick();
    applyStimulus(idle());
    check("pre_rst_free", 32'(free_entries), 32'd11);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_empty", 32'(empty),        32'd1);
    check("mid_rst_free",  32'(free_entries), 32'd16);
    check("mid_rst_ret",   32'(ret_valid),    32'd0);
    check("mid_rst_full",  32'(full),         32'd0);
    mq.delete();
    mhead = 0;
    #1;
    reset = 1'b0;
    tick();

    // Fill to full, then a refused request leaves the table alone.
    for (int j = 0; j < 10; j++) begin
      s = dispPair(fill_tab[j].den, int'(fill_tab[j].tn0), int'(fill_tab[j].to0),
                   int'(fill_tab[j].tn1), int'(fill_tab[j].to1));
      applyStimulus(s);
      check($sformatf("fill%0d_stall", j), 32'(disp_stall),   32'(fill_tab[j].exp_stall));
      check($sformatf("fill%0d_idx", j),   32'(disp_idx),     32'(fill_tab[j].exp_idx));
      check($sformatf("fill%0d_free", j),  32'(free_entries), 32'(fill_tab[j].exp_free));
      check($sformatf("fill%0d_full", j),  32'(full),         32'(fill_tab[j].exp_full));
      tick();
    end

    // Out-of-order completion, then retire with a same-cycle dispatch on a full ROB.
    applyStimulus(cdbStim(2'b01, 17, 0));
    check("ooo_none_a", 32'(ret_valid), 32'd0);
    tick();
    applyStimulus(cdbStim(2'b01, 16, 0));
    check("ooo_none_b", 32'(ret_valid), 32'd0);
    tick();
    s = dispPair(2'b11, 32, 56, 33, 57);
    applyStimulus(s);
    check("ooo_ret_valid", 32'(ret_valid),  32'h3);
    check("ooo_T_free",    32'(ret_T_free), 32'({6'd41, 6'd40}));
    check("ooo_T_arch",    32'(ret_T_arch), 32'({6'd17, 6'd16}));
    check("sim_stall",     32'(disp_stall), 32'd1);
    tick();
    applyStimulus(s);
    check("sim_accept", 32'(disp_stall), 32'd0);
    check("sim_idx",    32'(disp_idx),   32'h10);
    tick();

    // Retire through index 13 and dispatch across the wrap.
    for (int j = 1; j <= 6; j++) begin
      applyStimulus(cdbStim(2'b11, 16 + 2*j, 17 + 2*j));
      tick();
    end
    applyStimulus(idle());
    tick();
    applyStimulus(dispPair(2'b11, 34, 58, 35, 59));
    check("wrap_idx",      32'(disp_idx),     32'h32);
    check("wrap_free_pre", 32'(free_entries), 32'd12);
    tick();
    applyStimulus(idle());
    check("wrap_free", 32'(free_entries), 32'd10);
    check("wrap_full", 32'(full),         32'd0);
    check("wrap_empty", 32'(empty),       32'd0);
    tick();

    // Squash back to entry 4 with ten in flight.
    doReset();
    for (int j = 0; j < 5; j++) begin
      applyStimulus(dispPair(2'b11, 8 + 2*j, 30 + 2*j, 9 + 2*j, 31 + 2*j));
      tick();
    end
    s = dispPair(2'b11, 50, 51, 52, 53);
    s.sq   = 1'b1;
    s.sidx = 4'd4;
    applyStimulus(s);
    check("sq_stall", 32'(disp_stall), 32'd1);
    tick();
    applyStimulus(cdbStim(2'b01, 15, 0));
    check("sq_free", 32'(free_entries), 32'd11);
    check("sq_idx",  32'(disp_idx),     32'h65);
    tick();
    applyStimulus(idle());
    check("sq_no_mark",  32'(ret_valid),    32'd0);
    check("sq_free_hold", 32'(free_entries), 32'd11);
    tick();
    applyStimulus(cdbStim(2'b11, 8, 9));   tick();
    applyStimulus(cdbStim(2'b11, 10, 11)); tick();
    applyStimulus(cdbStim(2'b01, 12, 0));  tick();
    applyStimulus(idle());                 tick();
    applyStimulus(idle());
    check("sq_drain_empty", 32'(empty),        32'd1);
    check("sq_drain_free",  32'(free_entries), 32'd16);
    tick();

    // Randomized traffic including squashes and flushes.
    doReset();
    for (int c = 0; c < 400; c++) begin
      int cdb_pct;
      s = idle();
      cdb_pct = (c < 200) ? 30 : 70;
      case ($urandom_range(0, 3))
        0:       s.den = 2'b00;
        1:       s.den = 2'b01;
        default: s.den = 2'b11;
      endcase
      s.tn0 = PREG_W'(tag_ctr);
      s.tn1 = PREG_W'(tag_ctr + 1);
      tag_ctr += 2;
      s.to0 = PREG_W'($urandom);
      s.to1 = PREG_W'($urandom);
      if ($urandom_range(0, 99) < cdb_pct) begin s.cv[0] = 1'b1; s.ct0 = pickTag(); end
      if ($urandom_range(0, 99) < cdb_pct) begin s.cv[1] = 1'b1; s.ct1 = pickTag(); end
      if (mq.size() > 0 && $urandom_range(0, 11) == 0) begin
        s.sq   = 1'b1;
        s.sidx = IDX_W'((mhead + int'($urandom_range(0, mq.size() - 1))) % ROB_DEPTH);
      end
      if ($urandom_range(0, 59) == 0) s.flush = 1'b1;
      applyStimulus(s);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
